// File: rtl/elastic_threshold_monitor.sv
// elastic_threshold_monitor
// -------------------------
// Registered occupancy monitor for the PHY receive elastic buffer.
//
// Purpose:
//   - Converts the already-synchronised Gray read and write pointers to binary.
//   - Registers the fill level and derives full/empty from it.
//   - Raises SKP add/delete requests through a req/ack handshake. After each
//     acknowledged request it waits in a hold-off period so that the pointer
//     change can propagate back through the synchronisers.
//   - Sets a sticky flag when the raw occupancy is impossible, which means the
//     read pointer has overtaken the write pointer.
//
// Ports:
//   clk                - receive-domain clock
//   rst                - asynchronous, active-high reset
//   gray_read_pointer  - Gray read pointer (AW+1 bits), synchronised to clk
//   gray_write_pointer - Gray write pointer (AW+1 bits), synchronised to clk
//   skp_window         - high while a SKP ordered set may be added or removed
//   req_ack            - consumer accepted the pending add_req/delete_req
//   err_clr            - clears the sticky ptr_err (and the stats counters)
//   add_req            - request to insert one SKP symbol
//   delete_req         - request to remove one SKP symbol
//   level              - registered occupancy, 0..BUFFER_DEPTH
//   full               - level == BUFFER_DEPTH
//   empty              - level == 0
//   ptr_err            - sticky: raw occupancy exceeded BUFFER_DEPTH
//
// Optional feature (define ETM_STATS_EN):
//   add_cnt, del_cnt   - 16-bit saturating counts of acknowledged add and
//                        delete requests. err_clr also clears them.

module elastic_threshold_monitor #(
    parameter int BUFFER_DEPTH = 16,
    parameter int HIGH_TH      = 12,
    parameter int LOW_TH       = 4,
    parameter int HOLD_CYCLES  = 4,
    localparam int AW          = $clog2(BUFFER_DEPTH),
    localparam int PW          = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] gray_read_pointer,
    input  logic [PW-1:0] gray_write_pointer,
    input  logic          skp_window,
    input  logic          req_ack,
    input  logic          err_clr,
    output logic          add_req,
    output logic          delete_req,
    output logic [PW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          ptr_err
`ifdef ETM_STATS_EN
    ,
    output logic [15:0]   add_cnt,
    output logic [15:0]   del_cnt
`endif
);

    // The hold counter needs at least one bit, even when HOLD_CYCLES == 1.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
    localparam logic [PW-1:0] HIGH_P  = PW'(HIGH_TH);
    localparam logic [PW-1:0] LOW_P   = PW'(LOW_TH);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEL_PEND = 2'd1,
        ADD_PEND = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] raw;
    logic          raw_bad;

    // The pointers are one bit wider than the address. Because of that, the
    // modular difference is unambiguous over the full range 0..BUFFER_DEPTH.
    // Anything larger can only mean the read side ran past the write side.
    assign rd_bin  = gray2bin(gray_read_pointer);
    assign wr_bin  = gray2bin(gray_write_pointer);
    assign raw     = wr_bin - rd_bin;
    assign raw_bad = (raw > DEPTH_P);

    // Level register: a corrupt sample never reaches level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (!raw_bad) begin
            level <= raw;
        end
    end

    assign full  = (level == DEPTH_P);
    assign empty = (level == '0);

    // Sticky error: when a set and a clear happen in the same cycle, the set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_err <= 1'b0;
        end else if (raw_bad) begin
            ptr_err <= 1'b1;
        end else if (err_clr) begin
            ptr_err <= 1'b0;
        end
    end

    // Request FSM. The request outputs are registered and are updated together
    // with the state, so add_req and delete_req can never be high at once.
    // A pending request is never withdrawn. The consumer owns it until it
    // acknowledges it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            add_req    <= 1'b0;
            delete_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (skp_window && (level > HIGH_P)) begin
                        state      <= DEL_PEND;
                        delete_req <= 1'b1;
                    end else if (skp_window && (level < LOW_P)) begin
                        state   <= ADD_PEND;
                        add_req <= 1'b1;
                    end
                end
                DEL_PEND: begin
                    if (req_ack) begin
                        state      <= HOLD;
                        delete_req <= 1'b0;
                        hold_cnt   <= HOLD_LD;
                    end
                end
                ADD_PEND: begin
                    if (req_ack) begin
                        state    <= HOLD;
                        add_req  <= 1'b0;
                        hold_cnt <= HOLD_LD;
                    end
                end
                HOLD: begin
                    // Loaded with HOLD_CYCLES-1, so HOLD lasts exactly
                    // HOLD_CYCLES cycles. req_ack is ignored here.
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    add_req    <= 1'b0;
                    delete_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef ETM_STATS_EN
    // Count handshakes that completed. err_clr takes priority over an
    // increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_cnt <= '0;
            del_cnt <= '0;
        end else if (err_clr) begin
            add_cnt <= '0;
            del_cnt <= '0;
        end else begin
            if ((state == ADD_PEND) && req_ack && (add_cnt != 16'hFFFF)) begin
                add_cnt <= add_cnt + 16'd1;
            end
            if ((state == DEL_PEND) && req_ack && (del_cnt != 16'hFFFF)) begin
                del_cnt <= del_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
